// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle for the sequential multiply/divide unit.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] InA;
  logic [WIDTH-1:0] InB;
  logic [1:0]       Oper;
  logic             sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;
  logic             Zero;
  logic             Ofl;
  logic             DivZero;

  // Requester side: issues operations and consumes results
  modport master (
    output in_valid, InA, InB, Oper, sign, out_ready,
    input  in_ready, out_valid, Out, Zero, Ofl, DivZero
  );

  // Unit side
  modport slave (
    input  in_valid, InA, InB, Oper, sign, out_ready,
    output in_ready, out_valid, Out, Zero, Ofl, DivZero
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative MUL-low/MUL-high/DIV/REM unit, one bit per cycle; signed support under ALU_MULDIV_SIGNED_EN.
// Latency: out_valid rises WIDTH+1 edges after the accepting edge; initiation interval WIDTH+3.
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE.
module alu_muldiv_seq #(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  alu_muldiv_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d;   // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;   // multiplier shifting out / quotient shifting in
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             ofl_q, ofl_d;
  logic             divz_q, divz_d;

  logic             accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot, rem, res;
  logic             mul_ofl, div_ofl, res_ofl;

  assign accept = (state_q == IDLE) && bus.in_valid;

`ifdef ALU_MULDIV_SIGNED_EN
  logic sgn_q, sgn_d, neg_q, neg_d, rneg_q, rneg_d, sovf_q, sovf_d;
  logic a_neg, b_neg;

  assign a_neg = bus.sign & bus.InA[WIDTH-1];
  assign b_neg = bus.sign & bus.InB[WIDTH-1];
  assign a_mag = a_neg ? -bus.InA : bus.InA;
  assign b_mag = b_neg ? -bus.InB : bus.InB;

  // Sign bookkeeping registers, captured with the operands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sgn_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      sovf_q <= 1'b0;
    end else begin
      sgn_q  <= sgn_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      sovf_q <= sovf_d;
    end
  end

  // Sign flags load only on the accepting edge; most-negative / -1 is flagged up front
  always_comb begin
    sgn_d  = sgn_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    sovf_d = sovf_q;
    if (accept) begin
      sgn_d  = bus.sign;
      neg_d  = a_neg ^ b_neg;
      rneg_d = a_neg;
      sovf_d = bus.sign & bus.Oper[1] & (bus.InA == {1'b1, {(WIDTH-1){1'b0}}}) & (&bus.InB);
    end
  end

  // Undo the magnitude conversion on the finished product, quotient and remainder
  always_comb begin
    prod    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quot    = neg_q ? -lo_q : lo_q;
    rem     = rneg_q ? -hi_q : hi_q;
    mul_ofl = sgn_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                    : (|prod[2*WIDTH-1:WIDTH]);
    div_ofl = sovf_q;
  end
`else
  logic sign_unused;
  assign sign_unused = bus.sign;
  assign a_mag = bus.InA;
  assign b_mag = bus.InB;

  // Unsigned build: raw iteration results need no correction
  always_comb begin
    prod    = {hi_q, lo_q};
    quot    = lo_q;
    rem     = hi_q;
    mul_ofl = |hi_q;
    div_ofl = 1'b0;
  end
`endif

  // One shift-add or restoring shift-subtract step
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             diff_msb_unused;

  assign add_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {WIDTH{1'b0}})};
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, b_q};
  assign diff_msb_unused = div_diff[WIDTH];

  // Result selection; a zero divisor yields an all-ones quotient and the dividend as remainder
  always_comb begin
    case (op_q)
      2'b00:   begin res = prod[WIDTH-1:0];        res_ofl = mul_ofl; end
      2'b01:   begin res = prod[2*WIDTH-1:WIDTH];  res_ofl = 1'b0;    end
      2'b10:   begin res = dz_q ? {WIDTH{1'b1}} : quot; res_ofl = dz_q ? 1'b0 : div_ofl; end
      default: begin res = rem;                    res_ofl = dz_q ? 1'b0 : div_ofl; end
    endcase
  end

  // FSM next state and datapath updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    out_d   = out_q;
    zero_d  = zero_q;
    ofl_d   = ofl_q;
    divz_d  = divz_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.Oper;
          cnt_d   = CNT_W'(WIDTH);
          b_d     = bus.Oper[1] ? b_mag : a_mag;
          lo_d    = bus.Oper[1] ? a_mag : b_mag;
          hi_d    = {WIDTH{1'b0}};
          dz_d    = bus.Oper[1] & (bus.InB == {WIDTH{1'b0}});
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (op_q[1]) begin
          if (!div_diff[WIDTH+1]) begin
            hi_d = div_diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          hi_d = add_sum[WIDTH:1];
          lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        out_d   = res;
        zero_d  = (res == {WIDTH{1'b0}});
        ofl_d   = res_ofl;
        divz_d  = dz_q;
        state_d = DONE;
      end
      default: begin
        if (bus.out_ready) state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b1;
      ofl_q   <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      ofl_q   <= ofl_d;
      divz_q  <= divz_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Out       = out_q;
  assign bus.Zero      = zero_q;
  assign bus.Ofl       = ofl_q;
  assign bus.DivZero   = divz_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq at WIDTH=16: directed plan cases plus random operations.
// Expected results come from a plain-arithmetic reference model.
// Checks latency, hold under backpressure, non-acceptance in DONE and mid-operation reset.
module tb_alu_muldiv_seq;
  localparam int W = 16;

  logic clk;
  logic rst;

  alu_muldiv_seq_if #(.WIDTH(W)) bus ();

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the arithmetic the unit is meant to perform
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sg, output logic [W-1:0] o, output logic ofl,
                                output logic dz);
    logic        use_s;
    logic [31:0] pu;
    int          sa, sb, ps, lo_s;
    logic [31:0] qs, rs;
`ifdef ALU_MULDIV_SIGNED_EN
    use_s = sg;
`else
    use_s = 1'b0 & sg;
`endif
    dz  = op[1] && (b == 0);
    ofl = 1'b0;
    o   = '0;
    if (!use_s) begin
      pu = 32'(a) * 32'(b);
      case (op)
        2'b00: begin o = pu[15:0]; ofl = (pu[31:16] != 0); end
        2'b01: o = pu[31:16];
        2'b10: o = (b == 0) ? 16'hFFFF : a / b;
        default: o = (b == 0) ? a : a % b;
      endcase
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      ps = sa * sb;
      lo_s = $signed(ps[15:0]);
      case (op)
        2'b00: begin o = ps[15:0]; ofl = (lo_s != ps); end
        2'b01: o = ps[31:16];
        2'b10: begin
          if (sb == 0) o = 16'hFFFF;
          else if (sa == -32768 && sb == -1) begin o = 16'h8000; ofl = 1'b1; end
          else begin qs = sa / sb; o = qs[15:0]; end
        end
        default: begin
          if (sb == 0) o = a;
          else if (sa == -32768 && sb == -1) begin o = 16'h0000; ofl = 1'b1; end
          else begin rs = sa % sb; o = rs[15:0]; end
        end
      endcase
    end
  endfunction

  // One full transaction; entered and left #1 after a rising edge
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sg, input int hold);
    logic [W-1:0] e_out;
    logic         e_ofl, e_dz;
    int           t;
    int           edges;
    model(op, a, b, sg, e_out, e_ofl, e_dz);
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.InA       = a;
    bus.InB       = b;
    bus.Oper      = op;
    bus.sign      = sg;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    // Operand changes after acceptance must not matter
    bus.in_valid = 1'b0;
    bus.InA      = 16'($urandom);
    bus.InB      = 16'($urandom);
    bus.Oper     = 2'($urandom);
    bus.sign     = 1'($urandom);
    edges = 0;
    while (bus.out_valid !== 1'b1 && edges < 100) begin @(posedge clk); #1; edges++; end
    chk("latency", 64'(edges), 64'(W + 1));
    chk("out", 64'(bus.Out), 64'(e_out));
    chk("zero", 64'(bus.Zero), 64'(e_out == 0));
    chk("ofl", 64'(bus.Ofl), 64'(e_ofl));
    chk("divzero", 64'(bus.DivZero), 64'(e_dz));
    chk("done_in_ready", 64'(bus.in_ready), 64'd0);
    // A new request is offered throughout DONE and must be ignored
    bus.in_valid = 1'b1;
    bus.InA      = 16'($urandom);
    bus.InB      = 16'($urandom);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_out", 64'(bus.Out), 64'(e_out));
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", 64'(bus.out_valid), 64'd0);
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic       seen;
    logic [1:0] r_op;
    logic [W-1:0] r_a, r_b;

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.InA       = '0;
    bus.InB       = '0;
    bus.Oper      = 2'b00;
    bus.sign      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out", 64'(bus.Out), 64'd0);
    chk("rst_zero", 64'(bus.Zero), 64'd1);
    chk("rst_ofl", 64'(bus.Ofl), 64'd0);
    chk("rst_divzero", 64'(bus.DivZero), 64'd0);

    run_op(2'b00, 16'd7, 16'd6, 1'b0, 0);

    // Reset while BUSY aborts the operation
    bus.in_valid = 1'b1;
    bus.InA      = 16'hFFFF;
    bus.InB      = 16'hFFFF;
    bus.Oper     = 2'b00;
    bus.sign     = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_out", 64'(bus.Out), 64'd0);
    chk("abort_zero", 64'(bus.Zero), 64'd1);
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      seen = seen | bus.out_valid;
    end
    chk("abort_no_result", 64'(seen), 64'd0);

    run_op(2'b01, 16'hFFFF, 16'hFFFF, 1'b0, 0);
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 1'b0, 0);
    run_op(2'b10, 16'd100, 16'd7, 1'b0, 0);
    run_op(2'b11, 16'd100, 16'd7, 1'b0, 0);
    run_op(2'b10, 16'h0003, 16'h0005, 1'b0, 0);
    run_op(2'b10, 16'h1234, 16'h0000, 1'b0, 0);
    run_op(2'b11, 16'h1234, 16'h0000, 1'b0, 0);
    run_op(2'b10, 16'd100, 16'd7, 1'b0, 10);
    run_op(2'b10, 16'hFFF9, 16'h0002, 1'b1, 0);
    run_op(2'b11, 16'hFFF9, 16'h0002, 1'b1, 0);
    run_op(2'b10, 16'h8000, 16'hFFFF, 1'b1, 0);
    run_op(2'b11, 16'h8000, 16'hFFFF, 1'b1, 0);
    run_op(2'b10, 16'h8000, 16'hFFFF, 1'b0, 0);
    run_op(2'b11, 16'hFFF9, 16'h0000, 1'b1, 1);
    run_op(2'b00, 16'hFFFF, 16'h0001, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = 16'($urandom);
      r_b  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 5) == 0) r_b = 16'($urandom_range(0, 15));
      run_op(r_op, r_a, r_b, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
